audio_frame_sequencer: RTL and testbench

- Frame-level controller between the audio codec handshake and the effect chain (mute, distortion, echo, pitch, vinyl).
- Replaces the free-running combinational tick with a sequenced frame: capture one stereo sample, fire one chain tick, wait a fixed processing latency, capture the result, and write it when the codec allows.
- Also owns effect configuration: switches are synchronised and applied only at frame boundaries, and every config change soft-mutes output for a number of frames to suppress clicks.

---
 rtl/audio_frame_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_audio_frame_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : audio_frame_sequencer
// Description : Frame-level sequencer between the codec handshake and the
//               effect chain. Captures one stereo sample, strobes the chain
//               once, waits a fixed latency, captures the result and writes
//               it when the codec allows. Owns frame-aligned effect config
//               with a click-suppressing soft mute after every change.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_frame_sequencer #(
  parameter int PROC_LATENCY = 4,
  parameter int MUTE_FRAMES  = 16,
  parameter int SW_WIDTH     = 10
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic        [SW_WIDTH-1:0] sw_in,
  input  logic                       audio_in_available,
  input  logic                       audio_out_allowed,
  input  logic signed [31:0]         audio_in_L,
  input  logic signed [31:0]         audio_in_R,
  output logic                       read_audio_in,
  output logic                       write_audio_out,
  output logic signed [31:0]         audio_out_L,
  output logic signed [31:0]         audio_out_R,
  output logic signed [31:0]         chain_in_L,
  output logic signed [31:0]         chain_in_R,
  output logic                       chain_tick,
  input  logic signed [31:0]         chain_out_L,
  input  logic signed [31:0]         chain_out_R,
  output logic        [SW_WIDTH-1:0] cfg_sw,
  output logic        [15:0]         stall_count,
  output logic                       busy
);

  localparam logic [7:0]  c_LATENCY   = 8'(PROC_LATENCY);
  localparam logic [15:0] c_MUTE      = 16'(MUTE_FRAMES);
  localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PROCESS = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_accept;   // IDLE exit: consume sample, tick the chain
  logic w_capture;  // latency elapsed: latch chain output
  logic w_fire;     // codec ready: present held sample

  logic        [SW_WIDTH-1:0] r_sw_meta;
  logic        [SW_WIDTH-1:0] r_sw_sync;
  logic        [SW_WIDTH-1:0] r_cfg;
  logic        [15:0]         r_mute_cnt;
  logic        [7:0]          r_lat_cnt;
  logic                       r_read;
  logic                       r_tick;
  logic                       r_write;
  logic                       r_emit_wait;
  logic        [15:0]         r_stall_cnt;
  logic signed [31:0]         r_chain_in_L;
  logic signed [31:0]         r_chain_in_R;
  logic signed [31:0]         r_hold_L;
  logic signed [31:0]         r_hold_R;
  logic signed [31:0]         r_out_L;
  logic signed [31:0]         r_out_R;

  // Two-flop synchroniser for the asynchronous board switches.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Frame state register.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and frame event decode. The cycle carrying the write pulse is
  // already IDLE but is treated as turnaround, so a new read cannot start
  // until the cycle after the write.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (audio_in_available && !r_write) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_PROCESS;
        end
      end
      ST_PROCESS: begin
        if (r_lat_cnt == 8'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (audio_out_allowed) begin
          w_fire      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Input side: handshake pulses, sample latch, latency counter, config.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_read       <= 1'b0;
      r_tick       <= 1'b0;
      r_chain_in_L <= '0;
      r_chain_in_R <= '0;
      r_lat_cnt    <= '0;
      r_cfg        <= '0;
    end else begin
      r_read <= w_accept;
      r_tick <= w_accept;
      if (w_accept) begin
        r_chain_in_L <= audio_in_L;
        r_chain_in_R <= audio_in_R;
        r_lat_cnt    <= c_LATENCY;
        if (r_sw_sync != r_cfg) begin
          r_cfg <= r_sw_sync;
        end
      end else if (r_state == ST_PROCESS && r_lat_cnt != 8'd0) begin
        r_lat_cnt <= r_lat_cnt - 8'd1;
      end
    end
  end

  // Soft mute: reloaded on a config change, consumed one frame per capture.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_mute_cnt <= c_MUTE;
      r_hold_L   <= '0;
      r_hold_R   <= '0;
    end else begin
      if (w_accept && (r_sw_sync != r_cfg)) begin
        r_mute_cnt <= c_MUTE;
      end else if (w_capture) begin
        if (r_mute_cnt != 16'd0) begin
          r_hold_L   <= '0;
          r_hold_R   <= '0;
          r_mute_cnt <= r_mute_cnt - 16'd1;
        end else begin
          r_hold_L <= chain_out_L;
          r_hold_R <= chain_out_R;
        end
      end
    end
  end

  // Output side: write pulse, held output samples and stall accounting.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_write     <= 1'b0;
      r_out_L     <= '0;
      r_out_R     <= '0;
      r_emit_wait <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_write <= w_fire;
      if (r_state == ST_EMIT && !audio_out_allowed) begin
        r_emit_wait <= 1'b1;
      end
      if (w_fire) begin
        r_out_L     <= r_hold_L;
        r_out_R     <= r_hold_R;
        r_emit_wait <= 1'b0;
        if (r_emit_wait && r_stall_cnt != c_STALL_MAX) begin
          r_stall_cnt <= r_stall_cnt + 16'd1;
        end
      end
    end
  end

  assign read_audio_in   = r_read;
  assign chain_tick      = r_tick;
  assign write_audio_out = r_write;
  assign audio_out_L     = r_out_L;
  assign audio_out_R     = r_out_R;
  assign chain_in_L      = r_chain_in_L;
  assign chain_in_R      = r_chain_in_R;
  assign cfg_sw          = r_cfg;
  assign stall_count     = r_stall_cnt;
  assign busy            = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_audio_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_frame_sequencer
// Description : Self-checking bench for audio_frame_sequencer. Frames are
//               modelled from their observable timing rules; expected output
//               samples are queued on each read and popped on each write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_frame_sequencer;

  localparam int L  = 4;
  localparam int MF = 2;
  localparam int SW = 10;

  logic               CLOCK_50 = 1'b0;
  logic               resetn;
  logic [SW-1:0]      sw_in;
  logic               audio_in_available;
  logic               audio_out_allowed;
  logic signed [31:0] audio_in_L, audio_in_R;
  logic               read_audio_in, write_audio_out, chain_tick, busy;
  logic signed [31:0] audio_out_L, audio_out_R;
  logic signed [31:0] chain_in_L, chain_in_R;
  logic signed [31:0] chain_out_L, chain_out_R;
  logic [SW-1:0]      cfg_sw;
  logic [15:0]        stall_count;

  // Stand-in effect chain: constant in mode 0, simple bit transform in mode 1.
  logic mode;
  assign chain_out_L = mode ? (chain_in_L ^ 32'h0F0F_0F0F) : 32'h0000_1234;
  assign chain_out_R = mode ? ~chain_in_R                  : 32'h0000_5678;

  audio_frame_sequencer #(
    .PROC_LATENCY (L),
    .MUTE_FRAMES  (MF),
    .SW_WIDTH     (SW)
  ) dut (
    .CLOCK_50           (CLOCK_50),
    .resetn             (resetn),
    .sw_in              (sw_in),
    .audio_in_available (audio_in_available),
    .audio_out_allowed  (audio_out_allowed),
    .audio_in_L         (audio_in_L),
    .audio_in_R         (audio_in_R),
    .read_audio_in      (read_audio_in),
    .write_audio_out    (write_audio_out),
    .audio_out_L        (audio_out_L),
    .audio_out_R        (audio_out_R),
    .chain_in_L         (chain_in_L),
    .chain_in_R         (chain_in_R),
    .chain_tick         (chain_tick),
    .chain_out_L        (chain_out_L),
    .chain_out_R        (chain_out_R),
    .cfg_sw             (cfg_sw),
    .stall_count        (stall_count),
    .busy               (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard state ----------------
  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
  } pair_t;

  pair_t       sb[$];
  int          rd_cycles[$];
  pair_t       e;
  int          cyc       = 0;
  int          rd_cyc    = 0;
  int          last_wr   = -10;
  int          n_reads   = 0;
  int          n_writes  = 0;
  bit          inflight  = 0;
  bit          stalled   = 0;
  bit          rst_seen  = 0;
  bit          exp_read  = 0;
  bit          exp_write = 0;
  logic [SW-1:0] m_cfg   = '0;
  int          m_mute    = MF;
  logic [15:0] m_stall   = '0;
  logic [31:0] last_in_L = '0, last_in_R = '0;
  logic [31:0] prev_L    = '0, prev_R    = '0;

  function automatic pair_t chain_fn(input logic [31:0] l, input logic [31:0] r);
    pair_t p;
    p.l = mode ? (l ^ 32'h0F0F_0F0F) : 32'h0000_1234;
    p.r = mode ? ~r                  : 32'h0000_5678;
    return p;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge CLOCK_50) begin
    cyc++;
    if (rst_seen) begin
      chk_eq("rst_chain_in_L", chain_in_L, 32'h0);
      chk_eq("rst_chain_in_R", chain_in_R, 32'h0);
      chk_eq("rst_out_L", audio_out_L, 32'h0);
      chk_eq("rst_out_R", audio_out_R, 32'h0);
      chk_eq("rst_stall", stall_count, 32'h0);
      chk_eq("rst_tick", chain_tick, 32'h0);
    end
    chk_eq("read_timing", read_audio_in, exp_read);
    chk_eq("write_timing", write_audio_out, exp_write);
    chk_eq("tick_eq_read", chain_tick, read_audio_in);
    chk_eq("read_write_excl", read_audio_in & write_audio_out, 32'h0);

    if (read_audio_in) begin
      chk_eq("chain_in_L", chain_in_L, last_in_L);
      chk_eq("chain_in_R", chain_in_R, last_in_R);
      if (rd_cycles.size() > 0)
        chk_eq("read_spacing", ((cyc - rd_cycles[$]) >= L + 4), 32'h1);
      if (sw_in != m_cfg) begin
        m_cfg  = sw_in;
        m_mute = MF;
      end
      if (m_mute > 0) begin
        e = '0;
        m_mute--;
      end else begin
        e = chain_fn(last_in_L, last_in_R);
      end
      sb.push_back(e);
      rd_cycles.push_back(cyc);
      rd_cyc   = cyc;
      n_reads++;
      inflight = 1;
      stalled  = 0;
    end
    chk_eq("cfg_sw", cfg_sw, m_cfg);

    if (write_audio_out) begin
      chk_eq("sb_nonempty", (sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk_eq("out_L", audio_out_L, e.l);
        chk_eq("out_R", audio_out_R, e.r);
      end
      if (stalled) m_stall = (m_stall == 16'hFFFF) ? 16'hFFFF : m_stall + 16'd1;
      chk_eq("stall_count", stall_count, m_stall);
      inflight = 0;
      last_wr  = cyc;
      n_writes++;
    end else if (!rst_seen) begin
      chk_eq("out_hold_L", audio_out_L, prev_L);
      chk_eq("out_hold_R", audio_out_R, prev_R);
    end
    chk_eq("busy", busy, inflight);

    // Expectations for the cycle after the coming edge.
    if (!resetn) begin
      rst_seen  = 1;
      sb.delete();
      m_cfg     = '0;
      m_mute    = MF;
      m_stall   = '0;
      inflight  = 0;
      stalled   = 0;
      exp_read  = 0;
      exp_write = 0;
    end else begin
      rst_seen  = 0;
      exp_read  = !inflight && (cyc != last_wr) && audio_in_available;
      exp_write = inflight && (cyc >= rd_cyc + L + 1) && audio_out_allowed;
      if (inflight && (cyc >= rd_cyc + L + 1) && !audio_out_allowed) stalled = 1;
    end
    last_in_L = audio_in_L;
    last_in_R = audio_in_R;
    prev_L    = audio_out_L;
    prev_R    = audio_out_R;
  end

  // ---------------- bounded waits ----------------
  task automatic wait_writes(input int n, input int budget, input string tag);
    int target;
    int k;
    target = n_writes + n;
    k = 0;
    while (n_writes < target && k < budget) begin
      @(negedge CLOCK_50);
      #1;
      k++;
    end
    chk_eq(tag, (n_writes >= target), 32'h1);
  endtask

  task automatic wait_reads(input int n, input int budget, input string tag);
    int target;
    int k;
    target = n_reads + n;
    k = 0;
    while (n_reads < target && k < budget) begin
      @(negedge CLOCK_50);
      #1;
      k++;
    end
    chk_eq(tag, (n_reads >= target), 32'h1);
  endtask

  task automatic go_idle();
    audio_in_available = 1'b0;
    audio_out_allowed  = 1'b1;
    repeat (12) @(posedge CLOCK_50);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    resetn             = 1'b0;
    sw_in              = '0;
    audio_in_available = 1'b1;
    audio_out_allowed  = 1'b1;
    audio_in_L         = 32'h0000_0100;
    audio_in_R         = 32'h0000_0200;
    mode               = 1'b0;

    // Startup mute: two zero frames, then the chain value, 8-cycle frames.
    repeat (3) @(posedge CLOCK_50);
    #1;
    resetn = 1'b1;
    wait_writes(3, 60, "t1_three_writes");
    chk_eq("t1_spacing_a", rd_cycles[1] - rd_cycles[0], 32'd8);
    chk_eq("t1_spacing_b", rd_cycles[2] - rd_cycles[1], 32'd8);
    chk_eq("t1_third_L", audio_out_L, 32'h0000_1234);
    chk_eq("t1_stall", stall_count, 32'h0);

    // Single available pulse: read/tick for one cycle, write six cycles later.
    go_idle();
    audio_in_L         = 32'hFFFF_8000;
    audio_in_R         = 32'h0000_7FFF;
    audio_in_available = 1'b1;
    @(posedge CLOCK_50);
    #1;
    audio_in_available = 1'b0;
    wait_writes(1, 30, "t2_write");
    chk_eq("t2_latency", last_wr - rd_cycles[$], 32'd6);
    chk_eq("t2_chain_in_L", chain_in_L, 32'hFFFF_8000);
    chk_eq("t2_out_L", audio_out_L, 32'h0000_1234);

    // Switch change mid-frame: applied at the next IDLE exit, two muted writes.
    go_idle();
    mode               = 1'b1;
    audio_in_L         = 32'h1357_9BDF;
    audio_in_R         = 32'h2468_ACE0;
    audio_in_available = 1'b1;
    wait_reads(1, 30, "t3_read");
    @(posedge CLOCK_50);
    #1;
    sw_in = 10'h002;
    wait_writes(4, 80, "t3_writes");
    chk_eq("t3_cfg", cfg_sw, 32'h2);

    // Codec back-pressure for many cycles in EMIT.
    go_idle();
    audio_in_available = 1'b1;
    wait_reads(1, 30, "t4_read");
    @(posedge CLOCK_50);
    #1;
    audio_out_allowed = 1'b0;
    repeat (L + 11) @(posedge CLOCK_50);
    #1;
    audio_out_allowed = 1'b1;
    wait_writes(1, 30, "t4_write");
    chk_eq("t4_stall", stall_count, 32'h1);

    // Reset in the middle of PROCESS abandons the frame.
    wait_reads(1, 30, "t5_read");
    @(posedge CLOCK_50);
    #1;
    resetn             = 1'b0;
    audio_in_available = 1'b0;
    @(posedge CLOCK_50);
    #1;
    resetn = 1'b1;
    repeat (10) @(posedge CLOCK_50);
    #1;
    chk_eq("t5_no_write", n_writes == 9, 32'h1);
    chk_eq("t5_cfg", cfg_sw, 32'h0);
    audio_in_available = 1'b1;
    wait_writes(3, 60, "t5_restart");

    // Saturation of the stall counter.
    go_idle();
    force dut.r_stall_cnt = 16'hFFFE;
    m_stall = 16'hFFFE;
    @(posedge CLOCK_50);
    #1;
    release dut.r_stall_cnt;
    for (int i = 0; i < 2; i++) begin
      audio_in_available = 1'b1;
      wait_reads(1, 30, "t6_read");
      @(posedge CLOCK_50);
      #1;
      audio_in_available = 1'b0;
      audio_out_allowed  = 1'b0;
      repeat (10) @(posedge CLOCK_50);
      #1;
      audio_out_allowed = 1'b1;
      wait_writes(1, 30, "t6_write");
    end
    chk_eq("t6_saturated", stall_count, 32'hFFFF);

    // Randomized traffic with back-pressure and occasional config changes.
    go_idle();
    seen = n_reads;
    repeat (600) begin
      @(posedge CLOCK_50);
      #1;
      audio_in_available = ($urandom_range(0, 3) != 0);
      audio_out_allowed  = ($urandom_range(0, 2) != 0);
      audio_in_L         = $urandom;
      audio_in_R         = $urandom;
      if (n_reads != seen) begin
        seen = n_reads;
        if ($urandom_range(0, 2) == 0) sw_in = SW'($urandom_range(0, 3));
      end
    end
    go_idle();
    repeat (10) @(posedge CLOCK_50);
    #1;
    chk_eq("final_sb_empty", sb.size(), 32'h0);
    chk_eq("final_enough_frames", (n_writes > 40), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
